// File: rtl/heartbeat_mc.sv
// Multi-channel LED heartbeat generator: a shared phase-tick prescaler drives
// per-channel off/on/blink/heartbeat patterns, reconfigured through one pending slot.
module heartbeat_mc #(
  parameter int unsigned F_CLKIN    = 12_000_000,
  parameter int unsigned TICK_HZ    = 1_000,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PER_W      = 12,
  parameter logic [1:0]  DEF_MODE   = 2'b11,
  parameter int unsigned DEF_PERIOD = 1000
) (
  input  logic             clk_tb,
  input  logic             rst_tb,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [3:0]       i_cfg_ch,
  input  logic [1:0]       i_cfg_mode,
  input  logic [PER_W-1:0] i_cfg_period,
  input  logic             i_sync,
  output logic             o_tick,
  output logic [N_CH-1:0]  o_led
);

  localparam int unsigned      DIV     = F_CLKIN / TICK_HZ;
  localparam int unsigned      CNT_W   = (DIV > 32'd1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 32'd1);
  localparam logic [PER_W-1:0] PER_MIN = PER_W'(8);
  localparam logic [PER_W-1:0] DEF_PER = (DEF_PERIOD < 32'd8) ? PER_MIN : PER_W'(DEF_PERIOD);
  localparam logic [1:0]       M_OFF   = 2'b00;
  localparam logic [1:0]       M_ON    = 2'b01;
  localparam logic [1:0]       M_BLINK = 2'b10;
  localparam logic [1:0]       M_HB    = 2'b11;

  function automatic logic [PER_W-1:0] clamp_per(input logic [PER_W-1:0] p);
    clamp_per = (p < PER_MIN) ? PER_MIN : p;
  endfunction

  // Heartbeat lights segments 0 and 2 of eight equal segments of the period.
  function automatic logic led_decode(input logic [1:0] m, input logic [PER_W-1:0] p,
                                      input logic [PER_W-1:0] ph);
    logic [PER_W+1:0] s;
    logic [PER_W+1:0] ph_x;
    s    = (PER_W+2)'(p >> 3);
    ph_x = (PER_W+2)'(ph);
    case (m)
      M_OFF:   led_decode = 1'b0;
      M_ON:    led_decode = 1'b1;
      M_BLINK: led_decode = (ph < (p >> 1));
      M_HB:    led_decode = (ph_x < s) || ((ph_x >= (s << 1)) && (ph_x < ((s << 1) + s)));
      default: led_decode = 1'b0;
    endcase
  endfunction

  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             tick_edge_s;
  logic [1:0]       mode_q  [N_CH];
  logic [1:0]       mode_d  [N_CH];
  logic [PER_W-1:0] per_q   [N_CH];
  logic [PER_W-1:0] per_d   [N_CH];
  logic [PER_W-1:0] phase_q [N_CH];
  logic [PER_W-1:0] phase_d [N_CH];
  logic [N_CH-1:0]  led_q, led_d;
  logic [N_CH-1:0]  hit_s, apply_s;
  logic             pend_q, pend_d;
  logic [3:0]       pch_q, pch_d;
  logic [1:0]       pmode_q, pmode_d;
  logic [PER_W-1:0] pper_q, pper_d;
  logic             accept_s;
  logic             ch_ok_s;

  always_comb begin
    tick_edge_s = (presc_q == CNT_MAX);
    if (i_sync) begin
      presc_d = '0;
    end else if (tick_edge_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + CNT_W'(1);
    end
    tick_d = (presc_d == CNT_MAX);
  end

  // Pending config lands at the channel's wrap, or on the next tick for static modes.
  always_comb begin
    hit_s   = '0;
    apply_s = '0;
    led_d   = '0;
    for (int c = 0; c < N_CH; c++) begin
      mode_d[c]  = mode_q[c];
      per_d[c]   = per_q[c];
      phase_d[c] = phase_q[c];
      hit_s[c]   = pend_q && (pch_q == 4'(c));
      if (i_sync) begin
        phase_d[c] = '0;
        apply_s[c] = hit_s[c];
      end else if (tick_edge_s) begin
        if (hit_s[c] && ((mode_q[c] == M_OFF) || (mode_q[c] == M_ON) ||
                         (phase_q[c] == per_q[c] - PER_W'(1)))) begin
          apply_s[c] = 1'b1;
          phase_d[c] = '0;
        end else if (phase_q[c] == per_q[c] - PER_W'(1)) begin
          phase_d[c] = '0;
        end else begin
          phase_d[c] = phase_q[c] + PER_W'(1);
        end
      end else begin
        phase_d[c] = phase_q[c];
      end
      if (apply_s[c]) begin
        mode_d[c] = pmode_q;
        per_d[c]  = pper_q;
      end else begin
        mode_d[c] = mode_q[c];
        per_d[c]  = per_q[c];
      end
      led_d[c] = led_decode(mode_d[c], per_d[c], phase_d[c]);
    end
  end

  // Out-of-range channel writes handshake normally but never occupy the slot.
  always_comb begin
    ch_ok_s  = ({1'b0, i_cfg_ch} < 5'(N_CH));
    accept_s = i_cfg_valid && !pend_q;
    pend_d   = pend_q;
    pch_d    = pch_q;
    pmode_d  = pmode_q;
    pper_d   = pper_q;
    if (|apply_s) begin
      pend_d = 1'b0;
    end else if (accept_s && ch_ok_s) begin
      pend_d  = 1'b1;
      pch_d   = i_cfg_ch;
      pmode_d = i_cfg_mode;
      pper_d  = clamp_per(i_cfg_period);
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk_tb or negedge rst_tb) begin
    if (!rst_tb) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      led_q   <= '0;
      pend_q  <= 1'b0;
      pch_q   <= 4'd0;
      pmode_q <= 2'b00;
      pper_q  <= PER_MIN;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c]  <= DEF_MODE;
        per_q[c]   <= DEF_PER;
        phase_q[c] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      pend_q  <= pend_d;
      pch_q   <= pch_d;
      pmode_q <= pmode_d;
      pper_q  <= pper_d;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c]  <= mode_d[c];
        per_q[c]   <= per_d[c];
        phase_q[c] <= phase_d[c];
      end
    end
  end

  assign o_tick      = tick_q;
  assign o_led       = led_q;
  assign o_cfg_ready = !pend_q;

endmodule

// File: tb/tb_heartbeat_mc.sv
// Randomised + directed bench for heartbeat_mc: a tick/phase reference model
// pushes per-cycle expectations into a queue that an independent monitor drains.
module tb_heartbeat_mc;

  localparam int DIV  = 12;
  localparam int NCH  = 2;
  localparam int PW   = 12;
  localparam int DEFP = 16;

  logic          clk_tb       = 1'b0;
  logic          rst_tb       = 1'b0;
  logic          i_cfg_valid  = 1'b0;
  logic [3:0]    i_cfg_ch     = 4'd0;
  logic [1:0]    i_cfg_mode   = 2'b00;
  logic [PW-1:0] i_cfg_period = '0;
  logic          i_sync       = 1'b0;
  logic          o_cfg_ready;
  logic          o_tick;
  logic [NCH-1:0] o_led;

  heartbeat_mc #(
    .F_CLKIN(12_000), .TICK_HZ(1_000), .N_CH(NCH), .PER_W(PW),
    .DEF_MODE(2'b11), .DEF_PERIOD(DEFP)
  ) dut (
    .clk_tb(clk_tb), .rst_tb(rst_tb), .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready), .i_cfg_ch(i_cfg_ch), .i_cfg_mode(i_cfg_mode),
    .i_cfg_period(i_cfg_period), .i_sync(i_sync), .o_tick(o_tick), .o_led(o_led)
  );

  always #5 clk_tb = ~clk_tb;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NCH+1:0] exp_q[$];

  // Reference model state: cycles into the current tick, per-channel pattern state.
  int m_cnt;
  int m_phase[NCH];
  int m_mode[NCH];
  int m_per[NCH];
  bit m_pv;
  int m_pch, m_pmode, m_pper;

  function automatic bit exp_led(int mode, int phase, int per);
    int s;
    s = per / 8;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return phase < per / 2;
      default: return (phase < s) || (phase >= 2 * s && phase < 3 * s);
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_pv  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c]  = 3;
      m_per[c]   = (DEFP < 8) ? 8 : DEFP;
      m_phase[c] = 0;
    end
  endtask

  always @(posedge clk_tb) begin
    bit tick_now, rdy;
    logic [NCH-1:0] l;
    if (!rst_tb) begin
      model_reset();
    end else begin
      tick_now = (m_cnt == DIV - 1);
      rdy      = !m_pv;
      if (i_sync) begin
        m_cnt = 0;
        for (int c = 0; c < NCH; c++) m_phase[c] = 0;
        if (m_pv) begin
          m_mode[m_pch] = m_pmode;
          m_per[m_pch]  = m_pper;
          m_pv = 1'b0;
        end
      end else if (tick_now) begin
        m_cnt = 0;
        for (int c = 0; c < NCH; c++) begin
          if (m_pv && m_pch == c && (m_mode[c] < 2 || m_phase[c] == m_per[c] - 1)) begin
            m_mode[c]  = m_pmode;
            m_per[c]   = m_pper;
            m_phase[c] = 0;
            m_pv       = 1'b0;
          end else begin
            m_phase[c] = (m_phase[c] + 1) % m_per[c];
          end
        end
      end else begin
        m_cnt++;
      end
      if (i_cfg_valid && rdy && int'(i_cfg_ch) < NCH) begin
        m_pv    = 1'b1;
        m_pch   = int'(i_cfg_ch);
        m_pmode = int'(i_cfg_mode);
        m_pper  = (int'(i_cfg_period) < 8) ? 8 : int'(i_cfg_period);
      end
      for (int c = 0; c < NCH; c++) l[c] = exp_led(m_mode[c], m_phase[c], m_per[c]);
      exp_q.push_back({l, (m_cnt == DIV - 1), !m_pv});
    end
  end

  always @(posedge clk_tb) begin
    logic [NCH+1:0] e, got;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {o_led, o_tick, o_cfg_ready};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t got led=%b tick=%b rdy=%b expected led=%b tick=%b rdy=%b",
                 $time, got[NCH+1:2], got[1], got[0], e[NCH+1:2], e[1], e[0]);
      end
    end
  end

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic write_cfg(int ch, int mode, int per);
    int k = 0;
    while (!o_cfg_ready && k < 3000) begin
      @(negedge clk_tb);
      k++;
    end
    if (k == 3000) check("ready_timeout", 0, 1);
    i_cfg_valid  = 1'b1;
    i_cfg_ch     = 4'(ch);
    i_cfg_mode   = 2'(mode);
    i_cfg_period = PW'(per);
    @(negedge clk_tb);
    i_cfg_valid  = 1'b0;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!o_tick && k < 40) begin
      @(negedge clk_tb);
      k++;
    end
    if (k == 40) check("tick_timeout", 0, 1);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk_tb);
    rst_tb = 1'b0;
    #1;
    check({tag, "_led"}, int'(o_led), 0);
    check({tag, "_tick"}, int'(o_tick), 0);
    check({tag, "_ready"}, int'(o_cfg_ready), 1);
    i_cfg_valid = 1'b0;
    i_sync      = 1'b0;
    repeat (3) @(negedge clk_tb);
    check({tag, "_ready_held"}, int'(o_cfg_ready), 1);
    rst_tb = 1'b1;
  endtask

  initial begin
    repeat (4) @(negedge clk_tb);
    check("por_led", int'(o_led), 0);
    check("por_tick", int'(o_tick), 0);
    check("por_ready", int'(o_cfg_ready), 1);
    rst_tb = 1'b1;
    repeat (400) @(negedge clk_tb);

    // blink period 20 on ch0, written mid-period
    repeat (30) @(negedge clk_tb);
    write_cfg(0, 2, 20);
    repeat (600) @(negedge clk_tb);

    // ch1 on, then a second write held while the slot is busy
    write_cfg(1, 1, 16);
    i_cfg_valid = 1'b1; i_cfg_ch = 4'd1; i_cfg_mode = 2'b00; i_cfg_period = PW'(9);
    repeat (3) @(negedge clk_tb);
    i_cfg_valid = 1'b0;
    repeat (40) @(negedge clk_tb);
    write_cfg(1, 0, 10);
    repeat (40) @(negedge clk_tb);

    // period 3 clamps to 8
    write_cfg(0, 3, 3);
    repeat (400) @(negedge clk_tb);

    // out-of-range channel is discarded
    write_cfg(5, 1, 30);
    #1;
    check("bad_ch_ready", int'(o_cfg_ready), 1);
    repeat (30) @(negedge clk_tb);

    // sync coincident with a tick, pending write applied at once
    write_cfg(0, 2, 40);
    repeat (300) @(negedge clk_tb);
    write_cfg(1, 3, 24);
    wait_tick();
    i_sync = 1'b1;
    @(negedge clk_tb);
    i_sync = 1'b0;
    repeat (100) @(negedge clk_tb);

    // reset while a write is pending
    write_cfg(0, 3, 24);
    do_reset("rst_pend");
    repeat (200) @(negedge clk_tb);

    for (int i = 0; i < 4000; i++) begin
      i_cfg_valid  = ($urandom_range(0, 3) == 0);
      i_cfg_ch     = 4'($urandom_range(0, 3));
      i_cfg_mode   = 2'($urandom_range(0, 3));
      i_cfg_period = PW'($urandom_range(0, 48));
      i_sync       = ($urandom_range(0, 199) == 0);
      if (i == 2000) begin
        do_reset("rst_rand");
      end else begin
        @(negedge clk_tb);
      end
    end
    i_cfg_valid = 1'b0;
    i_sync      = 1'b0;
    repeat (50) @(negedge clk_tb);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/heartbeat_mc.md
HEARTBEAT_MC -- requirements
Module: heartbeat_mc

Interface
REQ-001 SHALL have parameter F_CLKIN, default 12_000_000: input clock frequency, Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1_000: phase tick rate, Hz; DIV = F_CLKIN/TICK_HZ, DIV >= 2.
REQ-003 SHALL have parameter N_CH, default 4: LED channel count, 1..16.
REQ-004 SHALL have parameter PER_W, default 12: period field width, ticks.
REQ-005 SHALL have parameter DEF_MODE, default 2'b11: mode of every channel after reset.
REQ-006 SHALL have parameter DEF_PERIOD, default 1000: period of every channel after reset, ticks.
REQ-007 SHALL have port clk_tb, input, 1: clock, rising edge.
REQ-008 SHALL have port rst_tb, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port i_cfg_valid, input, 1: config write request.
REQ-010 SHALL have port o_cfg_ready, output, 1: config slot free.
REQ-011 SHALL have port i_cfg_ch, input, 4: target channel.
REQ-012 SHALL have port i_cfg_mode, input, 2: 00 off, 01 on, 10 blink, 11 heartbeat.
REQ-013 SHALL have port i_cfg_period, input, PER_W: new period, ticks.
REQ-014 SHALL have port i_sync, input, 1: synchronous phase restart of all channels.
REQ-015 SHALL have port o_tick, output, 1: one-cycle pulse per phase tick.
REQ-016 SHALL have port o_led, output, N_CH: LED drive, active-high.

Function
REQ-017 Prescaler SHALL count 0..DIV-1. o_tick SHALL be high for exactly the cycle in which count = DIV-1. Count SHALL then return to 0.
REQ-018 Each channel SHALL hold mode, period P, and phase 0..P-1. Phase SHALL advance only on the edge ending an o_tick cycle. Phase SHALL wrap from P-1 to 0.
REQ-019 Effective period: P = max(i_cfg_period, 8); write values below 8 SHALL be stored as 8. Segment length S = P>>3.
REQ-020 LED decode:
- off -> 0.
- on -> 1.
- blink -> 1 when phase < P>>1.
- heartbeat -> 1 when phase < S, or when 2S <= phase < 3S.
REQ-021 o_led[c] SHALL be a register loaded with the decode of the next-state mode/phase, so o_led changes on the same edge as phase.
REQ-022 Handshake: a write is accepted on an edge where i_cfg_valid = 1 and o_cfg_ready = 1. ch, mode, and period SHALL be captured into a single pending slot. o_cfg_ready SHALL be 0 from the next cycle while the slot is occupied.
REQ-023 Pending config SHALL be applied at the target channel's next phase wrap; the new mode/period SHALL govern phase 0. If the current mode is off or on, the config SHALL instead be applied on the next o_tick edge. On apply, the slot SHALL be freed and o_cfg_ready SHALL be 1 the following cycle.
REQ-024 Write to i_cfg_ch >= N_CH SHALL be accepted and discarded. o_cfg_ready SHALL remain 1.
REQ-025 i_sync = 1 SHALL, on that edge:
- clear the prescaler and all phases to 0;
- apply any pending config immediately;
- suppress o_tick in the following cycle.
REQ-026 i_sync coincident with a tick SHALL take priority; no phase advance occurs.
REQ-027 If a period write lowers P below the current phase, the apply-at-wrap rule SHALL hold unchanged, since phase restarts at 0.
REQ-028 All outputs SHALL be registered except o_cfg_ready, which SHALL be the inverse of the slot-occupied flag.

Reset
REQ-029 rst_tb low SHALL asynchronously set:
- prescaler 0, all phases 0;
- modes = DEF_MODE, periods = max(DEF_PERIOD, 8);
- pending slot empty.
REQ-030 During reset, o_led SHALL be 0, o_tick 0, o_cfg_ready 1.
REQ-031 After rst_tb is released, the first o_tick SHALL occur in the DIV-th cycle.
REQ-032 After release, o_led SHALL reflect the phase-0 decode from the first clock edge onward.
REQ-033 Reset mid-operation SHALL discard any pending config.

Verification
Bench parameters: F_CLKIN=12_000, TICK_HZ=1_000 (DIV=12), N_CH=2, DEF_PERIOD=16.
REQ-034 Release reset, run 400 cycles -> o_tick every 12 cycles. Each o_led bit high for ticks 0-1 and 4-5 of each 16-tick period, low otherwise.
REQ-035 Write ch0 blink, period 20, mid-period -> o_cfg_ready low until the ch0 wrap. Then o_led[0] high for 10 ticks, low for 10 ticks. ch1 unaffected.
REQ-036 Write ch1 on; second write attempted while ready = 0 -> first write applied at the next o_tick, o_led[1] = 1. Second write ignored until re-asserted after ready returns.
REQ-037 Write period 3 to ch0 heartbeat -> stored as 8; pulses at ticks 0 and 2, period 8 ticks.
REQ-038 Assert i_sync on the same cycle as o_tick -> all phases 0, prescaler 0, next o_tick 12 cycles later, pending config applied.
REQ-039 Assert rst_tb low with a write pending -> o_led = 0 immediately, o_cfg_ready = 1. After release, defaults restored and the pending write lost.
